// File: rtl/fp_wb_arbiter_if.sv
// fp_wb_arbiter_if: producer handshakes, register-file write port and stall counter of the FP writeback arbiter
interface fp_wb_arbiter_if #(
  parameter int FLEN  = 64,
  parameter int CNT_W = 16
);
  logic            ld_valid, ld_ready, ld_sp;
  logic [4:0]      ld_rd;
  logic [FLEN-1:0] ld_data;
  logic            ex_valid, ex_ready, ex_sp;
  logic [4:0]      ex_rd;
  logic [FLEN-1:0] ex_data;
  logic            dv_valid, dv_ready, dv_sp;
  logic [4:0]      dv_rd;
  logic [FLEN-1:0] dv_data;
  logic            WE3;
  logic [4:0]      A3;
  logic [FLEN-1:0] WD3;
  logic [CNT_W-1:0] stall_cnt;
  logic            clr_cnt;
  modport master (
    output ld_valid, ld_rd, ld_data, ld_sp, ex_valid, ex_rd, ex_data, ex_sp,
           dv_valid, dv_rd, dv_data, dv_sp, clr_cnt,
    input  ld_ready, ex_ready, dv_ready, WE3, A3, WD3, stall_cnt
  );
  modport slave (
    input  ld_valid, ld_rd, ld_data, ld_sp, ex_valid, ex_rd, ex_data, ex_sp,
           dv_valid, dv_rd, dv_data, dv_sp, clr_cnt,
    output ld_ready, ex_ready, dv_ready, WE3, A3, WD3, stall_cnt
  );
endinterface

// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: round-robin merge of load/FPU/div results into one registered FP register-file write
module fp_wb_arbiter #(
  parameter int FLEN      = 64,
  parameter bit NANBOX_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic            clk,
  input logic            rst,
  fp_wb_arbiter_if.slave bus
);
  logic             r_we;
  logic [4:0]       r_a3;
  logic [FLEN-1:0]  r_wd3;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       w_v, w_gnt;
  logic [1:0]       w_p0, w_p1, w_p2, w_g;
  logic             w_any, w_contend, w_sp;
  logic [4:0]       w_rd;
  logic [FLEN-1:0]  w_data, w_wd;
  assign w_v  = {bus.dv_valid, bus.ex_valid, bus.ld_valid};
  // pointer value 3 is unreachable; fold it onto 0 so the search order stays defined
  assign w_p0 = (r_ptr == 2'd3) ? 2'd0 : r_ptr;
  assign w_p1 = (w_p0 == 2'd2) ? 2'd0 : w_p0 + 2'd1;
  assign w_p2 = (w_p1 == 2'd2) ? 2'd0 : w_p1 + 2'd1;
  assign w_g  = w_v[w_p0] ? w_p0 : w_v[w_p1] ? w_p1 : w_p2;
  assign w_any = |w_v;
  assign w_contend = (w_v[0] & w_v[1]) | (w_v[0] & w_v[2]) | (w_v[1] & w_v[2]);
  assign w_gnt = (w_any && rst) ? 3'b001 << w_g : 3'b000;
  assign bus.ld_ready = w_gnt[0];
  assign bus.ex_ready = w_gnt[1];
  assign bus.dv_ready = w_gnt[2];
  assign w_rd   = (w_g == 2'd0) ? bus.ld_rd   : (w_g == 2'd1) ? bus.ex_rd   : bus.dv_rd;
  assign w_data = (w_g == 2'd0) ? bus.ld_data : (w_g == 2'd1) ? bus.ex_data : bus.dv_data;
  assign w_sp   = (w_g == 2'd0) ? bus.ld_sp   : (w_g == 2'd1) ? bus.ex_sp   : bus.dv_sp;
  assign w_wd   = (NANBOX_EN && w_sp) ? {{(FLEN-32){1'b1}}, w_data[31:0]} : w_data;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we  <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
      r_ptr <= 2'd0;
      r_cnt <= '0;
    end else begin
      r_we <= w_any;
      if (w_any) begin
        r_a3  <= w_rd;
        r_wd3 <= w_wd;
        r_ptr <= (w_g == 2'd2) ? 2'd0 : w_g + 2'd1;
      end
      r_cnt <= bus.clr_cnt ? '0 : (w_contend && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;
    end
  end
  assign bus.WE3       = r_we;
  assign bus.A3        = r_a3;
  assign bus.WD3       = r_wd3;
  assign bus.stall_cnt = r_cnt;
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb_fp_wb_arbiter: directed and randomized checks of fp_wb_arbiter against a queue-free behavioural model
module tb_fp_wb_arbiter;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  bit          v[3];
  logic [4:0]  rd[3];
  logic [63:0] dat[3];
  bit          sp[3];
  bit          clr;
  int          ptr, cnt;
  logic        exp_we;
  logic [4:0]  exp_a3;
  logic [63:0] exp_wd;
  logic [2:0]  rdy;
  fp_wb_arbiter_if #(.FLEN(64), .CNT_W(CNT_W)) bus();
  fp_wb_arbiter #(.FLEN(64), .NANBOX_EN(1'b1), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int pick();
    for (int k = 0; k < 3; k++) if (v[(ptr + k) % 3]) return (ptr + k) % 3;
    return -1;
  endfunction
  task automatic drive();
    bus.ld_valid = v[0]; bus.ld_rd = rd[0]; bus.ld_data = dat[0]; bus.ld_sp = sp[0];
    bus.ex_valid = v[1]; bus.ex_rd = rd[1]; bus.ex_data = dat[1]; bus.ex_sp = sp[1];
    bus.dv_valid = v[2]; bus.dv_rd = rd[2]; bus.dv_data = dat[2]; bus.dv_sp = sp[2];
    bus.clr_cnt = clr;
  endtask
  task automatic model_reset();
    ptr = 0; cnt = 0; exp_we = 0; exp_a3 = 0; exp_wd = 0; clr = 0;
    for (int i = 0; i < 3; i++) begin v[i] = 0; rd[i] = 0; dat[i] = 0; sp[i] = 0; end
  endtask
  task automatic set_src(input int i, input logic [4:0] r, input logic [63:0] d, input bit s);
    v[i] = 1; rd[i] = r; dat[i] = d; sp[i] = s;
  endtask
  // one clock: check readies before the edge, advance the model at the edge, check registered outputs after it
  task automatic cycle();
    int g, n;
    logic [2:0] er;
    drive();
    #1;
    g = pick();
    er = 3'b000;
    if (rst && g >= 0) er[g] = 1'b1;
    rdy = {bus.dv_ready, bus.ex_ready, bus.ld_ready};
    check("ready", rdy, er);
    @(posedge clk);
    n = 0;
    foreach (v[i]) n += v[i];
    if (clr) cnt = 0;
    else if (n >= 2 && cnt < (1 << CNT_W) - 1) cnt++;
    exp_we = (g >= 0);
    if (g >= 0) begin
      exp_a3 = rd[g];
      exp_wd = sp[g] ? {32'hFFFF_FFFF, dat[g][31:0]} : dat[g];
      ptr = (g + 1) % 3;
      v[g] = 0;
    end
    #1;
    check("WE3", bus.WE3, exp_we);
    check("A3", bus.A3, exp_a3);
    check("WD3", bus.WD3, exp_wd);
    check("stall_cnt", bus.stall_cnt, cnt);
  endtask
  initial begin
    int waited;
    logic [4:0] seq [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    model_reset();
    for (int i = 0; i < 3; i++) set_src(i, 5'(i + 1), 64'h1234, 0);
    drive();
    #3;
    rdy = {bus.dv_ready, bus.ex_ready, bus.ld_ready};
    check("ready_in_reset", rdy, 3'b000);
    check("WE3_in_reset", bus.WE3, 0);
    model_reset();
    drive();
    #10 rst = 1'b1;
    for (int c = 0; c < 5; c++) cycle();
    check("t1_we", bus.WE3, 0);
    check("t1_cnt", bus.stall_cnt, 0);
    // all three producers valid continuously
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 3; i++) if (!v[i]) set_src(i, 5'(i + 1), {$urandom, $urandom}, 0);
      cycle();
      check("t4_a3", bus.A3, seq[c]);
    end
    for (int i = 0; i < 3; i++) v[i] = 0;
    cycle();
    set_src(1, 5'd7, 64'h4000_0000_0000_0000, 0);
    cycle();
    check("t2_ex_ready", rdy, 3'b010);
    check("t2_a3", bus.A3, 7);
    check("t2_wd", bus.WD3, 64'h4000_0000_0000_0000);
    cycle();
    check("t2_we_drop", bus.WE3, 0);
    set_src(0, 5'd3, 64'h0000_0000_3F80_0000, 1);
    cycle();
    check("t3_a3", bus.A3, 3);
    check("t3_wd", bus.WD3, 64'hFFFF_FFFF_3F80_0000);
    set_src(0, 5'd0, 64'h0000_0000_0000_0005, 0);
    cycle();
    check("f0_a3", bus.A3, 0);
    // fairness: ex always valid, dv pulsed
    for (int p = 0; p < 4; p++) begin
      set_src(2, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 1'($urandom));
      waited = 0;
      while (v[2] && waited < 4) begin
        if (!v[1]) set_src(1, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 0);
        cycle();
        waited++;
      end
      check("t5_dv_wait_ok", waited <= 2, 1);
    end
    for (int i = 0; i < 3; i++) v[i] = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 3; i++)
        if (!v[i] && $urandom_range(0, 1)) set_src(i, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 1'($urandom));
      clr = ($urandom_range(0, 15) == 0);
      cycle();
    end
    clr = 0;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 3; i++) if (!v[i]) set_src(i, 5'(i + 8), {$urandom, $urandom}, 0);
      cycle();
    end
    check("t6_sat", bus.stall_cnt, 4'hF);
    clr = 1;
    for (int i = 0; i < 3; i++) if (!v[i]) set_src(i, 5'(i + 8), {$urandom, $urandom}, 0);
    cycle();
    check("t6_clr", bus.stall_cnt, 0);
    clr = 0;
    for (int i = 0; i < 3; i++) v[i] = 0;
    set_src(0, 5'd9, 64'hDEAD_BEEF_0000_0001, 0);
    cycle();
    check("t6_we_before_rst", bus.WE3, 1);
    set_src(1, 5'd10, 64'h1, 0);
    drive();
    #2 rst = 1'b0;
    #1;
    check("t6_we_async", bus.WE3, 0);
    check("t6_ready_async", bus.ex_ready, 0);
    @(posedge clk);
    #1;
    check("t6_no_write", bus.WE3, 0);
    check("t6_a3_rst", bus.A3, 0);
    model_reset();
    drive();
    rst = 1'b1;
    cycle();
    check("t6_after_rst", bus.WE3, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
Writeback stage feeding the 32 x 64-bit FP register file's single write port (WE3/A3/WD3).
Merges results from three FP producers into one registered write per cycle:
- FP load unit (src 0)
- pipelined FPU add/mul/fma (src 1)
- iterative fdiv/fsqrt unit (src 2)

Arbitration is round-robin. The block NaN-boxes single-precision results and counts stall cycles for performance monitoring.

Parameters:
FLEN, 64, register/data width; WD3 width.
NANBOX_EN, 1, 1 = single-precision results get upper 32 bits forced to all-ones; 0 = data passed unchanged.
CNT_W, 16, width of saturating stall counter.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
ld_valid  in  1  load result available
ld_ready  out  1  load result accepted this cycle
ld_rd  in  5  load destination register
ld_data  in  FLEN  load result data
ld_sp  in  1  load result is single-precision (flw)
ex_valid, ex_ready, ex_rd, ex_data, ex_sp  as ld_*, for the FPU pipeline (src 1)
dv_valid, dv_ready, dv_rd, dv_data, dv_sp  as ld_*, for the div/sqrt unit (src 2)
WE3  out  1  register-file write enable (registered)
A3  out  5  register-file write address (registered)
WD3  out  FLEN  register-file write data (registered)
stall_cnt  out  CNT_W  cycles in which >=1 valid source was not granted, saturating
clr_cnt  in  1  synchronous clear of stall_cnt

Behaviour:
Reset (rst=0, asynchronous, any time):
- WE3=0, A3=0, WD3=0, stall_cnt=0, rr_ptr=0.
- All *_ready=0 while rst=0.
- A result granted in the cycle reset asserts is lost; no write occurs.

Handshake:
- A source transfer occurs on a rising edge where valid=1 and ready=1.
- ready is combinational from the valids and rr_ptr. Exactly one ready is high when any valid is high; none otherwise.
- A source must hold valid, rd, data and sp stable until accepted.
- ready never depends on downstream state: the register file always accepts.

Arbitration:
- rr_ptr is 2 bits, holding 0/1/2.
- Search order starts at rr_ptr: ptr, ptr+1, ptr+2, all mod 3. The first valid source is granted.
- After a grant to source g, rr_ptr <= (g+1) mod 3.
- No grant leaves rr_ptr unchanged.
- rr_ptr value 3 is unreachable. If it occurs, treat it as 0.

Latency:
- Accept at edge N -> WE3=1 with A3/WD3 from the granted source during cycle N+1 (one register stage).
- No accept at edge N -> WE3=0 in cycle N+1. A3/WD3 hold their previous values.
- Back-to-back grants give WE3=1 on consecutive cycles.

Data formatting:
- If NANBOX_EN=1 and sp=1: WD3 = {32'hFFFF_FFFF, data[31:0]}.
- Otherwise WD3 = data.

Destination f0:
- rd=0 is a legal FP destination and is passed through unchanged. No special-casing.

Same-rd conflicts:
- Two sources targeting the same rd in one cycle are serialised by round-robin. The later grant's write lands last.
- Ordering between producers is the issue logic's responsibility.

stall_cnt:
- Increments by 1 on each edge where the popcount of valids is >=2, i.e. at least one valid source is not granted.
- Saturates at all-ones; no wrap.
- clr_cnt=1 sets it to 0 on the edge and takes priority over increment.

Test Plan:
1. Reset release, all valids 0 for 5 cycles -> WE3=0, A3=0, WD3=0, stall_cnt=0, all ready=0.
2. ex_valid=1, ex_rd=7, ex_data=64'h4000_0000_0000_0000, ex_sp=0 for one cycle -> ex_ready=1 that cycle; next cycle WE3=1, A3=7, WD3=64'h4000_0000_0000_0000; following cycle WE3=0.
3. ld_valid=1, ld_rd=3, ld_data=64'h0000_0000_3F80_0000, ld_sp=1, NANBOX_EN=1 -> next cycle WD3=64'hFFFF_FFFF_3F80_0000, A3=3.
4. All three valid continuously from reset, rd=1/2/3 -> grant order src0, src1, src2, src0, …; A3 sequence 1,2,3,1 on consecutive cycles; stall_cnt +1 per cycle.
5. Round-robin fairness: hold ex_valid=1 always and pulse dv_valid=1 -> dv granted within 2 cycles. No source is ever starved for more than 2 grants.
6. stall_cnt: CNT_W=4 with 20 contention cycles -> saturates at 4'hF. Then clr_cnt=1 together with contention -> 0 next cycle. Then asserting rst mid-transfer -> WE3 drops to 0 immediately (asynchronous) and no write occurs.
